clk_divider_multi: RTL

Parametrised multi-channel successor to clk_divider. It produces NUM_CH independent divided clocks (newClk) plus single-cycle tick enables from one system clock. Each divisor is runtime-programmable with glitch-free, terminal-count-aligned updates. It sits in the VGA clocking path and drives the pixel-clock enable (100 MHz / 4 = 25 MHz) and slower animation/refresh ticks.

---
 rtl/clk_div_pkg.sv | 23 ++
 rtl/clk_div_chan.sv | 91 +++++++++
 rtl/clk_divider_multi.sv | 61 ++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the multi-channel clock divider
//
// Purpose : common widths, VGA divisor constants and the channel-select width function.
// Ports   : none (package).

package clk_div_pkg;

  localparam int CNT_W_DEFAULT = 16;

  // 100 MHz system clock down to the 25 MHz pixel enable.
  localparam int VGA_PIX_DIV   = 4;
  // One 800x525 frame of pixel enables, counted in pixel ticks.
  localparam int VGA_FRAME_DIV = 800 * 525;

  // Channel-select width: clog2(n), but never narrower than one bit.
  function automatic int sel_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, divisor registers, newClk/tick
//
// Purpose : divides clk by a runtime divisor; a new divisor waits in div_pend until the
//           current period wraps (or an align), so periods are never shortened.
// Ports   : clk, reset   - system clock, synchronous active-high reset
//           en, align    - count enable, in-phase restart
//           wr, wr_val   - validated divisor write for this channel
//           newClk, tick - divided clock and one-cycle period pulse (registered)
//           pend         - a written divisor is waiting to take effect

module clk_div_chan #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             align,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             newClk,
  output logic             tick,
  output logic             pend
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt, div_act, div_pend;
  logic [CNT_W-1:0] cnt_n, div_n, div_pend_n;
  logic             pend_n, tick_n, clk_n;
  logic             wrap;

  assign wrap = (cnt == div_act - 1'b1);

  always_comb begin
    cnt_n      = cnt;
    div_n      = div_act;
    div_pend_n = div_pend;
    pend_n     = pend;
    tick_n     = 1'b0;
    clk_n      = newClk;

    if (align) begin
      cnt_n = '0;
      if (pend) begin
        div_n  = div_pend;
        pend_n = 1'b0;
      end
    end else if (en) begin
      if (wrap) begin
        cnt_n  = '0;
        tick_n = 1'b1;
        if (pend) begin
          div_n  = div_pend;
          pend_n = 1'b0;
        end
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end

    // newClk follows the post-edge count and divisor; with en low it simply holds.
    if (align || en) clk_n = (cnt_n >= (div_n >> 1));

    // A write only ever lands in the pending slot, even when it coincides with a
    // wrap or align that is consuming the previous pending value this cycle.
    if (wr) begin
      div_pend_n = wr_val;
      pend_n     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      div_act  <= DEF;
      div_pend <= DEF;
      pend     <= 1'b0;
      tick     <= 1'b0;
      newClk   <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      div_act  <= div_n;
      div_pend <= div_pend_n;
      pend     <= pend_n;
      tick     <= tick_n;
      newClk   <= clk_n;
    end
  end

endmodule

// File: rtl/clk_divider_multi.sv
// rtl/clk_divider_multi.sv - NUM_CH programmable clock dividers with glitch-free divisor updates
//
// Purpose : top level; decodes divisor writes, flags rejected writes, and instantiates
//           one clk_div_chan per channel.
// Ports   : clk, reset          - system clock, synchronous active-high reset
//           en, align           - global count enable, in-phase restart of all channels
//           div_wr/sel/val      - divisor write strobe, target channel, divisor value
//           newClk, tick, pend  - per-channel divided clock, period pulse, pending flag
//           wr_err              - one-cycle pulse for a rejected write

module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH  = 2,
  parameter  int CNT_W   = CNT_W_DEFAULT,
  parameter  int DEF_DIV = VGA_PIX_DIV,
  localparam int SEL_W   = sel_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              align,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] newClk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend,
  output logic              wr_err
);

  // One extra bit so NUM_CH itself is representable when SEL_W is exactly clog2.
  localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

  logic wr_ok;

  assign wr_ok = div_wr && ({1'b0, div_sel} < NUM_CH_W) && (div_val != '0);

  always_ff @(posedge clk) begin
    if (reset) wr_err <= 1'b0;
    else       wr_err <= div_wr && !wr_ok;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .align (align),
      .wr    (wr_ok && (div_sel == SEL_W'(i))),
      .wr_val(div_val),
      .newClk(newClk[i]),
      .tick  (tick[i]),
      .pend  (pend[i])
    );
  end

endmodule
